// File: rtl/axi_bridge_tx_flit_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_bridge_tx_flit_packer: packs client segments into SEGS-slot flits    |
// | with header. Optional FLIT_PACKER_TIMEOUT_FLUSH_EN closes idle partials. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axi_bridge_tx_flit_packer #(
  parameter int IF_W      = 64,
  parameter int TUSER_W   = 16,
  parameter int SEGS      = 4,
  parameter int FLUSH_TMO = 16,
  localparam int FLIT_W   = SEGS * IF_W,
  localparam int HDR_W    = 3 * SEGS + TUSER_W,
  localparam int KEEP_W   = IF_W / 8,
  localparam int FKEEP_W  = FLIT_W / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IF_W-1:0]      cl_tx_data_i,
  input  logic [KEEP_W-1:0]    cl_tx_keep_i,
  input  logic [TUSER_W-1:0]   cl_tx_user_i,
  input  logic                 cl_tx_valid_i,
  input  logic                 cl_tx_sop_i,
  input  logic                 cl_tx_eop_i,
  output logic                 cl_tx_ready_o,
  output logic [FLIT_W-1:0]    flit_data_o,
  output logic [FKEEP_W-1:0]   flit_keep_o,
  output logic [HDR_W-1:0]     flit_hdr_o,
  output logic                 flit_valid_o,
  input  logic                 flit_ready_i,
  input  logic                 enable_i,
  output logic [31:0]          stat_flits_o,
  output logic [31:0]          stat_pad_slots_o,
  output logic                 ev_err_protocol_o
);

  localparam int SLOT_W = $clog2(SEGS);
  localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(SEGS - 1);

  logic [FLIT_W-1:0]  asm_data_q, asm_data_d;
  logic [FKEEP_W-1:0] asm_keep_q, asm_keep_d;
  logic [SEGS-1:0]    asm_vld_q, asm_vld_d;
  logic [SEGS-1:0]    asm_sop_q, asm_sop_d;
  logic [SEGS-1:0]    asm_eop_q, asm_eop_d;
  logic [TUSER_W-1:0] asm_user_q, asm_user_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               in_frame_q, in_frame_d;
  logic               asm_done_q, asm_done_d;

  logic [FLIT_W-1:0]  flit_data_q, flit_data_d;
  logic [FKEEP_W-1:0] flit_keep_q, flit_keep_d;
  logic [HDR_W-1:0]   flit_hdr_q, flit_hdr_d;
  logic               flit_valid_q, flit_valid_d;
  logic [31:0]        stat_flits_q, stat_flits_d;
  logic [31:0]        stat_pad_q, stat_pad_d;
  logic               err_q, err_d;

`ifdef FLIT_PACKER_TIMEOUT_FLUSH_EN
  logic [7:0]         idle_q, idle_d;
`endif

  logic              out_free;
  logic              seg_acc;
  logic              asm_clear;
  logic [SLOT_W-1:0] wr_slot;

  function automatic logic [31:0] popcount(input logic [SEGS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < SEGS; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  assign out_free      = !flit_valid_q || flit_ready_i;
  assign cl_tx_ready_o = enable_i && rst_ni && (!asm_done_q || out_free);
  assign seg_acc       = cl_tx_valid_i && cl_tx_ready_o;
  assign asm_clear     = asm_done_q && out_free;
  // A segment accepted alongside the hand-off lands in slot 0 of the fresh assembly.
  assign wr_slot       = asm_clear ? '0 : slot_q;

  always_comb begin
    asm_data_d   = asm_data_q;
    asm_keep_d   = asm_keep_q;
    asm_vld_d    = asm_vld_q;
    asm_sop_d    = asm_sop_q;
    asm_eop_d    = asm_eop_q;
    asm_user_d   = asm_user_q;
    slot_d       = slot_q;
    in_frame_d   = in_frame_q;
    asm_done_d   = asm_done_q;
    flit_data_d  = flit_data_q;
    flit_keep_d  = flit_keep_q;
    flit_hdr_d   = flit_hdr_q;
    flit_valid_d = flit_valid_q;
    stat_flits_d = stat_flits_q;
    stat_pad_d   = stat_pad_q;
    err_d        = 1'b0;
`ifdef FLIT_PACKER_TIMEOUT_FLUSH_EN
    idle_d       = idle_q;
`endif

    if (flit_valid_q && flit_ready_i) begin
      flit_valid_d = 1'b0;
      stat_flits_d = stat_flits_q + 32'd1;
      stat_pad_d   = stat_pad_q + (32'(SEGS) - popcount(flit_hdr_q[SEGS-1:0]));
    end

    if (asm_clear) begin
      flit_data_d  = asm_data_q;
      flit_keep_d  = asm_keep_q;
      flit_hdr_d   = {asm_user_q, asm_eop_q, asm_sop_q, asm_vld_q};
      flit_valid_d = 1'b1;
      asm_data_d   = '0;
      asm_keep_d   = '0;
      asm_vld_d    = '0;
      asm_sop_d    = '0;
      asm_eop_d    = '0;
      asm_user_d   = '0;
      slot_d       = '0;
      asm_done_d   = 1'b0;
    end

    if (seg_acc) begin
      if (!cl_tx_sop_i && !in_frame_q) begin
        // Orphan continuation segment: dropped without touching assembly state.
        err_d = 1'b1;
      end else begin
        err_d = cl_tx_sop_i && in_frame_q;
        for (int k = 0; k < SEGS; k++) begin
          if (wr_slot == SLOT_W'(k)) begin
            asm_data_d[k*IF_W +: IF_W]     = cl_tx_data_i;
            asm_keep_d[k*KEEP_W +: KEEP_W] = cl_tx_keep_i;
            asm_vld_d[k]                   = 1'b1;
            asm_sop_d[k]                   = cl_tx_sop_i;
            asm_eop_d[k]                   = cl_tx_eop_i;
          end
        end
        if (wr_slot == '0) asm_user_d = cl_tx_user_i;
        in_frame_d = !cl_tx_eop_i;
        if (cl_tx_eop_i || wr_slot == c_last_slot) begin
          asm_done_d = 1'b1;
          slot_d     = '0;
        end else begin
          slot_d     = wr_slot + SLOT_W'(1);
        end
      end
    end

`ifdef FLIT_PACKER_TIMEOUT_FLUSH_EN
    if (seg_acc || asm_clear) begin
      idle_d = '0;
    end else if (|asm_vld_q && !asm_done_q) begin
      idle_d = idle_q + 8'd1;
      // Force-close without eop; in_frame stays set so the frame continues in the next flit.
      if (idle_d == 8'(FLUSH_TMO)) begin
        asm_done_d = 1'b1;
        slot_d     = '0;
        idle_d     = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_data_q   <= '0;
      asm_keep_q   <= '0;
      asm_vld_q    <= '0;
      asm_sop_q    <= '0;
      asm_eop_q    <= '0;
      asm_user_q   <= '0;
      slot_q       <= '0;
      in_frame_q   <= 1'b0;
      asm_done_q   <= 1'b0;
      flit_data_q  <= '0;
      flit_keep_q  <= '0;
      flit_hdr_q   <= '0;
      flit_valid_q <= 1'b0;
      stat_flits_q <= '0;
      stat_pad_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      asm_data_q   <= asm_data_d;
      asm_keep_q   <= asm_keep_d;
      asm_vld_q    <= asm_vld_d;
      asm_sop_q    <= asm_sop_d;
      asm_eop_q    <= asm_eop_d;
      asm_user_q   <= asm_user_d;
      slot_q       <= slot_d;
      in_frame_q   <= in_frame_d;
      asm_done_q   <= asm_done_d;
      flit_data_q  <= flit_data_d;
      flit_keep_q  <= flit_keep_d;
      flit_hdr_q   <= flit_hdr_d;
      flit_valid_q <= flit_valid_d;
      stat_flits_q <= stat_flits_d;
      stat_pad_q   <= stat_pad_d;
      err_q        <= err_d;
    end
  end

`ifdef FLIT_PACKER_TIMEOUT_FLUSH_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`endif

  assign flit_data_o       = flit_data_q;
  assign flit_keep_o       = flit_keep_q;
  assign flit_hdr_o        = flit_hdr_q;
  assign flit_valid_o      = flit_valid_q;
  assign stat_flits_o      = stat_flits_q;
  assign stat_pad_slots_o  = stat_pad_q;
  assign ev_err_protocol_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_bridge_tx_flit_packer.sv
`default_nettype none
// Directed self-checking bench for axi_bridge_tx_flit_packer (IF_W=64, SEGS=4).
module tb_axi_bridge_tx_flit_packer;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [63:0]  cl_tx_data_i;
  logic [7:0]   cl_tx_keep_i;
  logic [15:0]  cl_tx_user_i;
  logic         cl_tx_valid_i, cl_tx_sop_i, cl_tx_eop_i;
  logic         cl_tx_ready_o;
  logic [255:0] flit_data_o;
  logic [31:0]  flit_keep_o;
  logic [27:0]  flit_hdr_o;
  logic         flit_valid_o;
  logic         flit_ready_i;
  logic         enable_i;
  logic [31:0]  stat_flits_o, stat_pad_slots_o;
  logic         ev_err_protocol_o;

  int checks   = 0;
  int failures = 0;

  logic [255:0] q_data[$];
  logic [31:0]  q_keep[$];
  logic [27:0]  q_hdr[$];

  axi_bridge_tx_flit_packer #(
    .IF_W(64), .TUSER_W(16), .SEGS(4), .FLUSH_TMO(16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .cl_tx_data_i     (cl_tx_data_i),
    .cl_tx_keep_i     (cl_tx_keep_i),
    .cl_tx_user_i     (cl_tx_user_i),
    .cl_tx_valid_i    (cl_tx_valid_i),
    .cl_tx_sop_i      (cl_tx_sop_i),
    .cl_tx_eop_i      (cl_tx_eop_i),
    .cl_tx_ready_o    (cl_tx_ready_o),
    .flit_data_o      (flit_data_o),
    .flit_keep_o      (flit_keep_o),
    .flit_hdr_o       (flit_hdr_o),
    .flit_valid_o     (flit_valid_o),
    .flit_ready_i     (flit_ready_i),
    .enable_i         (enable_i),
    .stat_flits_o     (stat_flits_o),
    .stat_pad_slots_o (stat_pad_slots_o),
    .ev_err_protocol_o(ev_err_protocol_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_ni && flit_valid_o && flit_ready_i) begin
      q_data.push_back(flit_data_o);
      q_keep.push_back(flit_keep_o);
      q_hdr.push_back(flit_hdr_o);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [15:0] u,
                      input logic s, input logic e);
    int n;
    cl_tx_data_i  = d;
    cl_tx_keep_i  = k;
    cl_tx_user_i  = u;
    cl_tx_sop_i   = s;
    cl_tx_eop_i   = e;
    cl_tx_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cl_tx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cl_tx_ready_o) chk("send_timeout", {255'd0, cl_tx_ready_o}, 256'd1);
    @(posedge clk);
    #1;
    cl_tx_valid_i = 1'b0;
  endtask

  task automatic check_flit(input string tag, input logic [27:0] eh,
                            input logic [255:0] ed, input logic [31:0] ek);
    chk({tag, "_present"}, {255'd0, q_hdr.size() > 0}, 256'd1);
    if (q_hdr.size() > 0) begin
      chk({tag, "_hdr"},  256'(q_hdr.pop_front()),  256'(eh));
      chk({tag, "_data"}, q_data.pop_front(),       ed);
      chk({tag, "_keep"}, 256'(q_keep.pop_front()), 256'(ek));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int k, post, first_c, last_c, seen_at;
    logic [27:0] hold_hdr;

    rst_ni = 1'b0; enable_i = 1'b1; flit_ready_i = 1'b1;
    cl_tx_valid_i = 1'b0; cl_tx_sop_i = 1'b0; cl_tx_eop_i = 1'b0;
    cl_tx_data_i = '0; cl_tx_keep_i = '0; cl_tx_user_i = '0;
    #12;
    chk("rst_valid", {255'd0, flit_valid_o}, 256'd0);
    chk("rst_ready", {255'd0, cl_tx_ready_o}, 256'd0);
    chk("rst_hdr",   256'(flit_hdr_o), 256'd0);
    chk("rst_stats", {192'd0, stat_flits_o, stat_pad_slots_o}, 256'd0);
    @(negedge clk); rst_ni = 1'b1;
    cycles(1);
    chk("ready_after_rst", {255'd0, cl_tx_ready_o}, 256'd1);

    // Full 4-segment frame, checks closing latency.
    for (int i = 0; i < 4; i++)
      send(64'h1000 + 64'(i), 8'hFF, (i == 0) ? 16'h00A0 : 16'h0BAD, i == 0, i == 3);
    chk("t1_valid_n1", {255'd0, flit_valid_o}, 256'd0);
    cycles(1);
    chk("t1_valid_n2", {255'd0, flit_valid_o}, 256'd1);
    cycles(1);
    check_flit("t1", {16'h00A0, 4'h8, 4'h1, 4'hF},
               {64'h1003, 64'h1002, 64'h1001, 64'h1000}, 32'hFFFF_FFFF);
    chk("t1_stat_flits", 256'(stat_flits_o), 256'd1);
    chk("t1_stat_pad",   256'(stat_pad_slots_o), 256'd0);

    // Single-segment frame then a 6-segment frame.
    send(64'h2000, 8'h0F, 16'h00B1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      send(64'h3000 + 64'(i), 8'hFF, 16'hC200 + 16'(i), i == 0, i == 5);
    cycles(5);
    check_flit("t2a", {16'h00B1, 4'h1, 4'h1, 4'h1}, {192'd0, 64'h2000}, 32'h0000_000F);
    check_flit("t2b", {16'hC200, 4'h0, 4'h1, 4'hF},
               {64'h3003, 64'h3002, 64'h3001, 64'h3000}, 32'hFFFF_FFFF);
    check_flit("t2c", {16'hC204, 4'h2, 4'h0, 4'h3},
               {128'd0, 64'h3005, 64'h3004}, 32'h0000_FFFF);
    chk("t2_stat_flits", 256'(stat_flits_o), 256'd4);
    chk("t2_stat_pad",   256'(stat_pad_slots_o), 256'd5);

    // Backpressure: 20 cycles with flit_ready_i low during continuous input.
    k = 0; post = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      flit_ready_i = (c >= 20);
      cl_tx_valid_i = (k < 12);
      cl_tx_data_i  = 64'hD000 + 64'(k);
      cl_tx_keep_i  = 8'hFF;
      cl_tx_user_i  = 16'hE000 + 16'(k);
      cl_tx_sop_i   = (k % 4 == 0);
      cl_tx_eop_i   = (k % 4 == 3);
      @(negedge clk);
      if (c == 8)  chk("t3_ready_drop", {255'd0, cl_tx_ready_o}, 256'd0);
      if (c == 19) begin
        chk("t3_accepted_before", 256'(k), 256'd8);
        chk("t3_hold_valid", {255'd0, flit_valid_o}, 256'd1);
        chk("t3_hold_hdr",   256'(flit_hdr_o), 256'({16'hE000, 4'h8, 4'h1, 4'hF}));
        chk("t3_hold_data",  flit_data_o, {64'hD003, 64'hD002, 64'hD001, 64'hD000});
      end
      if (cl_tx_valid_i && cl_tx_ready_o) begin
        k++;
        if (c >= 20) begin
          post++;
          if (first_c < 0) first_c = c;
          last_c = c;
        end
      end
      @(posedge clk); #1;
    end
    cl_tx_valid_i = 1'b0;
    chk("t3_post_count", 256'(post), 256'd4);
    chk("t3_no_bubble",  256'(last_c - first_c), 256'd3);
    for (int j = 0; j < 3; j++)
      check_flit($sformatf("t3_f%0d", j),
                 {16'hE000 + 16'(4 * j), 4'h8, 4'h1, 4'hF},
                 {64'hD003 + 64'(4 * j), 64'hD002 + 64'(4 * j),
                  64'hD001 + 64'(4 * j), 64'hD000 + 64'(4 * j)}, 32'hFFFF_FFFF);
    chk("t3_extra_flits", 256'(q_hdr.size()), 256'd0);
    chk("t3_stat_flits",  256'(stat_flits_o), 256'd7);

    // Protocol errors.
    send(64'h4444, 8'hFF, 16'h0044, 1'b0, 1'b0);
    chk("t4_orphan_err", {255'd0, ev_err_protocol_o}, 256'd1);
    cycles(1);
    chk("t4_err_pulse_end", {255'd0, ev_err_protocol_o}, 256'd0);
    cycles(3);
    chk("t4_orphan_no_flit", {255'd0, flit_valid_o}, 256'd0);
    send(64'h4000, 8'hFF, 16'h00F0, 1'b1, 1'b0);
    send(64'h4001, 8'hFF, 16'h00F1, 1'b0, 1'b0);
    chk("t4_no_err_mid", {255'd0, ev_err_protocol_o}, 256'd0);
    send(64'h4002, 8'hFF, 16'h00F2, 1'b1, 1'b0);
    chk("t4_sop_mid_err", {255'd0, ev_err_protocol_o}, 256'd1);
    send(64'h4003, 8'hFF, 16'h00F3, 1'b0, 1'b1);
    cycles(4);
    check_flit("t4", {16'h00F0, 4'h8, 4'h5, 4'hF},
               {64'h4003, 64'h4002, 64'h4001, 64'h4000}, 32'hFFFF_FFFF);
    chk("t4_stat_flits", 256'(stat_flits_o), 256'd8);

    // Partial flit left open, then idle.
    send(64'h5000, 8'hFF, 16'h0055, 1'b1, 1'b0);
    send(64'h5001, 8'hFF, 16'h0056, 1'b0, 1'b0);
    seen_at = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (seen_at < 0 && flit_valid_o) seen_at = i;
    end
`ifdef FLIT_PACKER_TIMEOUT_FLUSH_EN
    chk("t5_tmo_latency", 256'(seen_at), 256'd17);
    check_flit("t5_tmo", {16'h0055, 4'h0, 4'h1, 4'h3},
               {128'd0, 64'h5001, 64'h5000}, 32'h0000_FFFF);
    hold_hdr = {16'h0057, 4'h1, 4'h0, 4'h1};
`else
    chk("t5_no_flit", {255'd0, seen_at >= 0}, 256'd0);
    hold_hdr = {16'h0055, 4'h4, 4'h1, 4'h7};
`endif

    // Held output flit plus a new frame in assembly, then async reset.
    q_hdr.delete(); q_data.delete(); q_keep.delete();
    flit_ready_i = 1'b0;
    send(64'h5002, 8'hFF, 16'h0057, 1'b0, 1'b1);
    cycles(2);
    chk("t6_held_valid", {255'd0, flit_valid_o}, 256'd1);
    chk("t6_held_hdr",   256'(flit_hdr_o), 256'(hold_hdr));
    send(64'h6000, 8'hFF, 16'h0066, 1'b1, 1'b0);
    #3 rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", {255'd0, flit_valid_o}, 256'd0);
    chk("t6_rst_data",  flit_data_o, 256'd0);
    chk("t6_rst_keep",  256'(flit_keep_o), 256'd0);
    chk("t6_rst_hdr",   256'(flit_hdr_o), 256'd0);
    chk("t6_rst_stats", {192'd0, stat_flits_o, stat_pad_slots_o}, 256'd0);
    chk("t6_rst_ready", {255'd0, cl_tx_ready_o}, 256'd0);
    @(negedge clk); rst_ni = 1'b1; flit_ready_i = 1'b1;
    cycles(1);
    for (int i = 0; i < 4; i++)
      send(64'h7000 + 64'(i), 8'hFF, 16'h0077, i == 0, i == 3);
    cycles(4);
    check_flit("t6_fresh", {16'h0077, 4'h8, 4'h1, 4'hF},
               {64'h7003, 64'h7002, 64'h7001, 64'h7000}, 32'hFFFF_FFFF);
    chk("t6_stat_flits", 256'(stat_flits_o), 256'd1);
    chk("t6_stat_pad",   256'(stat_pad_slots_o), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
